registers_bank_mp: RTL and testbench
====================================

Name: registers_bank_mp

Overview:
Parametrised multi-port successor of the ID-stage registers bank. It provides RD_PORTS combinational read ports and WR_PORTS synchronous write ports, with per-byte write enables and optional same-cycle write-to-read bypass. Register 0 can be hardwired to zero, and flush is either a single-cycle clear or a sequenced sweep with a busy flag. All contents are exported on a flat debug bus for the debug unit.

Parameters:
REGISTERS_BANK_SIZE, 32, number of registers (need not be a power of 2); AW = $clog2(REGISTERS_BANK_SIZE)
REGISTERS_SIZE, 32, register width in bits (multiple of 8); BYTES = REGISTERS_SIZE/8
RD_PORTS, 2, number of read ports (1..4)
WR_PORTS, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = R0 reads 0 and ignores writes
BYPASS, 1, 1 = a read returns this cycle's write data to the same address
FLUSH_MODE, 0, 0 = single-cycle clear; 1 = sweep that clears one register per cycle

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_flush  in  1  flush request (level, sampled on clock edge)
i_write_enable  in  WR_PORTS  per-port write enable
i_byte_enable  in  WR_PORTS*BYTES  per-port byte mask, bit 0 = byte 0 (LSB)
i_addr_wr  in  WR_PORTS*AW  write addresses, port p at [p*AW +: AW]
i_bus_wr  in  WR_PORTS*REGISTERS_SIZE  write data
i_addr_rd  in  RD_PORTS*AW  read addresses
o_bus_rd  out  RD_PORTS*REGISTERS_SIZE  read data, combinational
o_flush_busy  out  1  sweep in progress (always 0 when FLUSH_MODE=0)
o_bus_debug  out  REGISTERS_BANK_SIZE*REGISTERS_SIZE  all registers, R_k at [k*REGISTERS_SIZE +: REGISTERS_SIZE]

Behaviour:
- Reset (async): all registers = 0, sweep counter = 0, o_flush_busy = 0, so o_bus_rd = 0 and o_bus_debug = 0 immediately. Reset asserted mid-sweep aborts the sweep.
- Write: on the rising edge, if i_write_enable[p], the address is < REGISTERS_BANK_SIZE, and the address is not (ZERO_REG and 0), each byte with i_byte_enable bit set is updated. Bytes with the enable bit clear keep their value.
- Multiple ports writing the same address: merge per byte; where enables overlap, the highest port index wins.
- Read: o_bus_rd[r] = stored value of i_addr_rd[r]. The read returns 0 if the address is out of range, or if it is R0 and ZERO_REG=1.
- BYPASS=1: a read matching an active write address (same cycle, writable, not busy) returns the stored value with enabled bytes replaced by the write data, using the same priority merge as the write. BYPASS=0: the new value is visible the cycle after the edge.
- Flush, FLUSH_MODE=0: i_flush high at an edge clears all registers that edge. Flush has priority over any same-edge write.
- Flush, FLUSH_MODE=1, two states:
  - IDLE: i_flush=1 -> SWEEP, counter = 0, o_flush_busy = 1 from the next cycle.
  - SWEEP: each edge clears R[counter] and increments the counter. At counter = REGISTERS_BANK_SIZE-1 the last register is cleared and the state returns to IDLE; o_flush_busy = 0 after exactly REGISTERS_BANK_SIZE busy cycles.
  - While busy: all writes are ignored, bypass is disabled, and reads return current (partially cleared) contents. i_flush while busy is ignored (no restart).
- Latency: reads 0 cycles (combinational); writes visible next cycle (same cycle with BYPASS).

Decomposition:
- Package registers_bank_pkg: flush state encoding (FLUSH_IDLE, FLUSH_SWEEP) and a localparam/function for byte-mask merge width.
- Sub-module registers_bank_flush_seq holds the sweep FSM and counter. Outputs: busy, clear_en, clear_addr. It is instantiated only when FLUSH_MODE=1.

Test Plan (each scenario assumes RD_PORTS=2, WR_PORTS=2, REGISTERS_BANK_SIZE=10, with the FLUSH_MODE given in the scenario):
1. Basic write/read, FLUSH_MODE=0, BYPASS=0, ZERO_REG=1: write 0xDEADBEEF to R3 via port 0 with full mask, then read R3 on port 1 -> 0xDEADBEEF the next cycle. Write 0x12345678 to R0 -> R0 still reads 0 and o_bus_debug[31:0] = 0.
2. Byte enables and port priority, FLUSH_MODE=0, BYPASS=0: R5 = 0x11223344. In one cycle, port 0 writes 0xAAAAAAAA with mask 0011 and port 1 writes 0xBBBBBBBB with mask 0110. Result: R5 = 0x11BBBBAA.
3. Bypass, FLUSH_MODE=0, BYPASS=1: R7 = 0x00000000. Write 0xCAFEF00D to R7 with full mask while reading R7 in the same cycle -> o_bus_rd = 0xCAFEF00D before the edge. Repeat with BYPASS=0 -> 0x00000000 before the edge.
4. Out-of-range address, FLUSH_MODE=0, REGISTERS_BANK_SIZE=10: write 0xFFFFFFFF to address 12 -> no register changes and o_bus_debug is unchanged. Read address 12 -> 0.
5. Single-cycle flush, FLUSH_MODE=0: fill R1..R9, then assert i_flush together with a write to R2 -> all registers read 0 after the edge. o_flush_busy stays 0 throughout.
6. Sweep flush and reset, FLUSH_MODE=1: fill R1..R9 = k, then pulse i_flush. Expect o_flush_busy high for 10 cycles, and after cycle n registers 0..n-1 = 0 while the rest are intact. A write during busy is ignored. In a second run, assert i_reset mid-sweep -> all registers = 0 and o_flush_busy = 0 immediately.

Source files
------------

// File: rtl/registers_bank_pkg.sv
// Shared types and helpers for the multi-port registers bank.
package registers_bank_pkg;

  typedef enum logic {
    FLUSH_IDLE,
    FLUSH_SWEEP
  } flush_state_t;

  // Number of byte lanes (and byte-enable bits) for a register of the given width.
  function automatic int unsigned byte_lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/registers_bank_flush_seq.sv
// Sequenced flush: clears one register per cycle and reports busy while sweeping.
module registers_bank_flush_seq
  import registers_bank_pkg::*;
#(
  parameter int unsigned BANK_SIZE = 32,
  parameter int unsigned AW        = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  output logic          o_busy,
  output logic          o_clear_en,
  output logic [AW-1:0] o_clear_addr
);

  flush_state_t  state, state_next;
  logic [AW-1:0] cnt, cnt_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= FLUSH_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    o_clear_en = 1'b0;
    case (state)
      FLUSH_IDLE: begin
        if (i_flush) begin
          state_next = FLUSH_SWEEP;
          cnt_next   = '0;
        end
      end
      FLUSH_SWEEP: begin
        o_clear_en = 1'b1;
        if (cnt == AW'(BANK_SIZE - 1)) begin
          state_next = FLUSH_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = FLUSH_IDLE;
    endcase
  end

  assign o_busy       = (state == FLUSH_SWEEP);
  assign o_clear_addr = cnt;

endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port registers bank: combinational reads, byte-masked synchronous writes,
// optional write-to-read bypass, hardwired R0 and single-cycle or swept flush.
module registers_bank_mp
  import registers_bank_pkg::*;
#(
  parameter int unsigned REGISTERS_BANK_SIZE = 32,
  parameter int unsigned REGISTERS_SIZE      = 32,
  parameter int unsigned RD_PORTS            = 2,
  parameter int unsigned WR_PORTS            = 1,
  parameter int unsigned ZERO_REG            = 1,
  parameter int unsigned BYPASS              = 1,
  parameter int unsigned FLUSH_MODE          = 0,
  localparam int unsigned AW                 = $clog2(REGISTERS_BANK_SIZE),
  localparam int unsigned BYTES              = byte_lanes(REGISTERS_SIZE)
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_flush,
  input  logic [WR_PORTS-1:0]                           i_write_enable,
  input  logic [WR_PORTS*BYTES-1:0]                     i_byte_enable,
  input  logic [WR_PORTS*AW-1:0]                        i_addr_wr,
  input  logic [WR_PORTS*REGISTERS_SIZE-1:0]            i_bus_wr,
  input  logic [RD_PORTS*AW-1:0]                        i_addr_rd,
  output logic [RD_PORTS*REGISTERS_SIZE-1:0]            o_bus_rd,
  output logic                                          o_flush_busy,
  output logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] o_bus_debug
);

  logic [REGISTERS_SIZE-1:0] regs [REGISTERS_BANK_SIZE];

  logic          flush_busy;
  logic          clear_en;
  logic [AW-1:0] clear_addr;

  logic [AW-1:0] waddr [WR_PORTS];
  logic          wr_ok [WR_PORTS];

  generate
    if (FLUSH_MODE == 1) begin : g_sweep
      registers_bank_flush_seq #(
        .BANK_SIZE (REGISTERS_BANK_SIZE),
        .AW        (AW)
      ) u_flush_seq (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .o_busy       (flush_busy),
        .o_clear_en   (clear_en),
        .o_clear_addr (clear_addr)
      );
    end else begin : g_no_sweep
      assign flush_busy = 1'b0;
      assign clear_en   = 1'b0;
      assign clear_addr = '0;
    end
  endgenerate

  assign o_flush_busy = flush_busy;

  always_comb begin
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      waddr[p] = i_addr_wr[p*AW +: AW];
      wr_ok[p] = i_write_enable[p] && !flush_busy
                 && (32'(waddr[p]) < REGISTERS_BANK_SIZE)
                 && !((ZERO_REG != 0) && (waddr[p] == '0));
    end
  end

  // Ports are applied in ascending order so the highest index wins on overlapping bytes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned k = 0; k < REGISTERS_BANK_SIZE; k++) regs[k] <= '0;
    end else if ((FLUSH_MODE == 0) && i_flush) begin
      for (int unsigned k = 0; k < REGISTERS_BANK_SIZE; k++) regs[k] <= '0;
    end else if (clear_en) begin
      regs[clear_addr] <= '0;
    end else begin
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (wr_ok[p] && i_byte_enable[p*BYTES + b])
            regs[waddr[p]][b*8 +: 8] <= i_bus_wr[p*REGISTERS_SIZE + b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0]             raddr;
    logic [REGISTERS_SIZE-1:0] rdata;
    o_bus_rd = '0;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      raddr = i_addr_rd[r*AW +: AW];
      rdata = '0;
      if ((32'(raddr) < REGISTERS_BANK_SIZE) && !((ZERO_REG != 0) && (raddr == '0)))
        rdata = regs[raddr];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < WR_PORTS; p++) begin
          for (int unsigned b = 0; b < BYTES; b++) begin
            if (wr_ok[p] && (waddr[p] == raddr) && i_byte_enable[p*BYTES + b])
              rdata[b*8 +: 8] = i_bus_wr[p*REGISTERS_SIZE + b*8 +: 8];
          end
        end
      end
      o_bus_rd[r*REGISTERS_SIZE +: REGISTERS_SIZE] = rdata;
    end
  end

  always_comb begin
    o_bus_debug = '0;
    for (int unsigned k = 0; k < REGISTERS_BANK_SIZE; k++)
      o_bus_debug[k*REGISTERS_SIZE +: REGISTERS_SIZE] = regs[k];
  end

endmodule

// File: tb/tb_registers_bank_mp.sv
// Directed bench for registers_bank_mp: three instances (plain, bypass, swept flush) share write stimulus.
module tb_registers_bank_mp;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush_ab, flush_c;
  logic [1:0]     we;
  logic [7:0]     be;
  logic [7:0]     addr_wr;
  logic [63:0]    bus_wr;
  logic [7:0]     addr_rd;
  logic [63:0]    rd_a, rd_b, rd_c;
  logic           busy_a, busy_b, busy_c;
  logic [N*W-1:0] dbg_a, dbg_b, dbg_c;

  logic [W-1:0]   mdl [N];
  logic [N*W-1:0] exp_q [$];
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W), .RD_PORTS(2), .WR_PORTS(2),
    .ZERO_REG(1), .BYPASS(0), .FLUSH_MODE(0)
  ) u_a (
    .i_clk(clk), .i_reset(reset), .i_flush(flush_ab), .i_write_enable(we),
    .i_byte_enable(be), .i_addr_wr(addr_wr), .i_bus_wr(bus_wr), .i_addr_rd(addr_rd),
    .o_bus_rd(rd_a), .o_flush_busy(busy_a), .o_bus_debug(dbg_a)
  );

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W), .RD_PORTS(2), .WR_PORTS(2),
    .ZERO_REG(1), .BYPASS(1), .FLUSH_MODE(0)
  ) u_b (
    .i_clk(clk), .i_reset(reset), .i_flush(flush_ab), .i_write_enable(we),
    .i_byte_enable(be), .i_addr_wr(addr_wr), .i_bus_wr(bus_wr), .i_addr_rd(addr_rd),
    .o_bus_rd(rd_b), .o_flush_busy(busy_b), .o_bus_debug(dbg_b)
  );

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W), .RD_PORTS(2), .WR_PORTS(2),
    .ZERO_REG(1), .BYPASS(0), .FLUSH_MODE(1)
  ) u_c (
    .i_clk(clk), .i_reset(reset), .i_flush(flush_c), .i_write_enable(we),
    .i_byte_enable(be), .i_addr_wr(addr_wr), .i_bus_wr(bus_wr), .i_addr_rd(addr_rd),
    .o_bus_rd(rd_c), .o_flush_busy(busy_c), .o_bus_debug(dbg_c)
  );

  function automatic logic [W-1:0] fill(input int k);
    return 32'(k) * 32'h0101_0101;
  endfunction

  function automatic logic [N*W-1:0] flat_mdl();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = mdl[k];
    return v;
  endfunction

  // Image of the swept instance after n sweep edges: R0..R(n-1) cleared, the rest hold fill(k).
  function automatic logic [N*W-1:0] sweep_img(input int n);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 0 || k < n) ? '0 : fill(k);
    return v;
  endfunction

  task automatic expect_val(input logic [N*W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [N*W-1:0] obs);
    logic [N*W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    we = '0; be = '0; addr_wr = '0; bus_wr = '0;
    flush_ab = 1'b0; flush_c = 1'b0;
  endtask

  task automatic drv_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [3:0] m);
    we[p] = 1'b1;
    addr_wr[p*AW +: AW] = a;
    bus_wr[p*W +: W] = d;
    be[p*4 +: 4] = m;
  endtask

  task automatic rd(input int r, input logic [AW-1:0] a);
    addr_rd[r*AW +: AW] = a;
  endtask

  // Applies the bank semantics of the non-swept instances to the model, then advances one edge.
  task automatic tick();
    if (flush_ab) begin
      for (int k = 0; k < N; k++) mdl[k] = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (we[p] && addr_wr[p*AW +: AW] < N && addr_wr[p*AW +: AW] != 0) begin
          for (int b = 0; b < 4; b++)
            if (be[p*4 + b]) mdl[addr_wr[p*AW +: AW]][b*8 +: 8] = bus_wr[p*W + b*8 +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) mdl[k] = '0;
    reset = 1'b1;
    addr_rd = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_val('0); check("reset_rd_a", rd_a);
    expect_val('0); check("reset_dbg_a", dbg_a);
    expect_val('0); check("reset_dbg_c", dbg_c);
    expect_val('0); check("reset_busy_c", busy_c);
    @(negedge clk);
    reset = 1'b0;

    // Basic write/read and hardwired R0
    drv_wr(0, 4'd3, 32'hDEAD_BEEF, 4'hF);
    tick(); idle();
    rd(1, 4'd3); #1;
    expect_val(32'hDEAD_BEEF); check("basic_r3", rd_a[63:32]);
    drv_wr(0, 4'd0, 32'h1234_5678, 4'hF);
    tick(); idle();
    rd(0, 4'd0); #1;
    expect_val('0); check("r0_read", rd_a[31:0]);
    expect_val('0); check("r0_debug", dbg_a[31:0]);

    // Byte enables with port priority on overlapping bytes
    drv_wr(0, 4'd5, 32'h1122_3344, 4'hF);
    tick(); idle();
    drv_wr(0, 4'd5, 32'hAAAA_AAAA, 4'b0011);
    drv_wr(1, 4'd5, 32'hBBBB_BBBB, 4'b0110);
    tick(); idle();
    rd(0, 4'd5); #1;
    expect_val(32'h11BB_BBAA); check("merge_a", rd_a[31:0]);
    expect_val(32'h11BB_BBAA); check("merge_b", rd_b[31:0]);

    // Same-cycle bypass vs registered read
    rd(0, 4'd7); rd(1, 4'd5);
    drv_wr(0, 4'd7, 32'hCAFE_F00D, 4'hF);
    drv_wr(1, 4'd5, 32'h9900_0000, 4'b1000);
    #1;
    expect_val(32'hCAFE_F00D); check("bypass_on_r7", rd_b[31:0]);
    expect_val(32'h0000_0000); check("bypass_off_r7", rd_a[31:0]);
    expect_val(32'h99BB_BBAA); check("bypass_on_r5_mask", rd_b[63:32]);
    expect_val(32'h11BB_BBAA); check("bypass_off_r5", rd_a[63:32]);
    tick(); idle();
    expect_val(32'hCAFE_F00D); check("post_edge_r7", rd_a[31:0]);
    expect_val(32'h99BB_BBAA); check("post_edge_r5", rd_a[63:32]);

    // Out-of-range address
    rd(0, 4'd12);
    drv_wr(0, 4'd12, 32'hFFFF_FFFF, 4'hF);
    #1;
    expect_val('0); check("oor_bypass_read", rd_b[31:0]);
    tick(); idle();
    expect_val(flat_mdl()); check("oor_debug_a", dbg_a);
    expect_val('0); check("oor_read", rd_a[31:0]);

    // Fill R1..R9, then single-cycle flush racing a write
    for (int k = 1; k < N; k++) begin
      drv_wr(0, AW'(k), fill(k), 4'hF);
      tick(); idle();
    end
    expect_val(flat_mdl()); check("fill_debug_a", dbg_a);
    expect_val(sweep_img(0)); check("fill_debug_c", dbg_c);
    flush_ab = 1'b1;
    drv_wr(0, 4'd2, fill(2), 4'hF);
    tick(); idle();
    expect_val('0); check("flush_debug_a", dbg_a);
    expect_val('0); check("flush_debug_b", dbg_b);
    expect_val(flat_mdl()); check("flush_model", dbg_a);
    expect_val('0); check("flush_busy_a", busy_a);
    rd(0, 4'd2); rd(1, 4'd9); #1;
    expect_val('0); check("flush_rd_a", rd_a);

    // Swept flush: busy for N cycles, write and re-flush ignored while busy
    flush_c = 1'b1;
    tick(); idle();
    expect_val(1); check("sweep_busy_start", busy_c);
    for (int n = 1; n <= N; n++) begin
      if (n == 3) drv_wr(0, 4'd8, 32'hFFFF_FFFF, 4'hF);
      if (n == 5) flush_c = 1'b1;
      tick(); idle();
      expect_val(sweep_img(n)); check($sformatf("sweep_dbg_%0d", n), dbg_c);
      expect_val((n < N) ? 1 : 0); check($sformatf("sweep_busy_%0d", n), busy_c);
    end
    tick();
    expect_val(0); check("sweep_no_restart", busy_c);

    // Reset asserted mid-sweep
    for (int k = 1; k < N; k++) begin
      drv_wr(0, AW'(k), fill(k), 4'hF);
      tick(); idle();
    end
    expect_val(sweep_img(0)); check("refill_debug_c", dbg_c);
    flush_c = 1'b1;
    tick(); idle();
    repeat (3) tick();
    expect_val(sweep_img(3)); check("mid_sweep_debug_c", dbg_c);
    #2;
    reset = 1'b1;
    #1;
    expect_val(0); check("reset_mid_busy", busy_c);
    expect_val('0); check("reset_mid_debug_c", dbg_c);
    @(negedge clk);
    reset = 1'b0;
    tick();
    expect_val(0); check("reset_no_resume", busy_c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
